// File: rtl/bg_word_bridge.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : bg_word_bridge
//  Purpose  : Pixel-rate bridge between the background-model memory
//             controller FIFOs and the per-pixel update logic. Unpacks
//             1024-bit read words into one 64-bit model per pixel, packs
//             updated models back into 1024-bit write words, and tracks
//             frame-length, alignment and underrun errors.
//  Revision : 1.0 - initial release
// ============================================================================
module bg_word_bridge #(
    parameter int PIX_W        = 64,
    parameter int PIX_PER_WORD = 16,
    parameter int IMG_PIXELS   = 720 * 576
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ready,
    input  logic                          frame_valid,
    input  logic                          de,
    input  logic [PIX_W*PIX_PER_WORD-1:0] fifo_rd_data,
    input  logic                          fifo_rd_empty,
    output logic                          fifo_rd_en,
    output logic [PIX_W-1:0]              model_out,
    output logic                          model_valid,
    input  logic [PIX_W-1:0]              model_in,
    input  logic                          model_in_valid,
    output logic [PIX_W*PIX_PER_WORD-1:0] fifo_wr_data,
    output logic                          fifo_wr_en,
    output logic [3:0]                    status
);

    localparam int c_WORD_W = PIX_W * PIX_PER_WORD;
    localparam int c_IDX_W  = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int c_CNT_W  = 20;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(PIX_PER_WORD - 1);
    localparam logic [c_CNT_W-1:0] c_IMG_CNT  = c_CNT_W'(IMG_PIXELS);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;

    // Sticky status bit positions
    localparam int c_ST_FRAME = 0;   // pixel count or read alignment wrong at frame end
    localparam int c_ST_WRAL  = 1;   // write packer not word-aligned at frame end
    localparam int c_ST_DE    = 2;   // pixel outside an armed frame / before RUN
    localparam int c_ST_UFLOW = 3;   // word switch with no prefetched word

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME0 = 3'd1,
        ST_PRIME1 = 3'd2,
        ST_PRIME2 = 3'd3,
        ST_RUN    = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_prime_pop;

    // Read path registers
    logic                r_fifo_rd_en;
    logic                r_rd_vld;      // fifo_rd_data holds a freshly popped word
    logic                r_req;         // refill pending, not yet popped
    logic                r_uflow;       // cur_word zeroed, waiting for a refill
    logic [c_WORD_W-1:0] r_cur_word;
    logic [c_WORD_W-1:0] r_next_word;
    logic                r_next_ok;
    logic [c_IDX_W-1:0]  r_rd_idx;
    logic [PIX_W-1:0]    r_model_out;
    logic                r_model_valid;

    // Frame tracking
    logic               r_fv_d;
    logic               r_armed;
    logic [c_CNT_W-1:0] r_pix_cnt;
    logic [3:0]         r_status;

    // Write path registers
    logic [c_IDX_W-1:0]  r_wr_idx;
    logic [c_WORD_W-1:0] r_wr_word;
    logic [c_WORD_W-1:0] r_fifo_wr_data;
    logic                r_fifo_wr_en;
    logic [c_WORD_W-1:0] w_wr_merged;

    // Combinational strobes
    logic             w_run;
    logic             w_can_pop;
    logic             w_refill_pop;
    logic             w_pop;
    logic             w_fv_rise;
    logic             w_fv_fall;
    logic             w_armed_now;
    logic             w_pix;
    logic             w_bad_de;
    logic             w_switch;
    logic             w_run_cap;
    logic             w_uflow_evt;
    logic             w_frame_end;
    logic [PIX_W-1:0] w_cur_lane;

    assign w_run        = (r_state == ST_RUN);
    // Pops are never issued back to back so the empty flag seen here
    // already reflects the previous pop.
    assign w_can_pop    = !fifo_rd_empty && !r_fifo_rd_en;
    assign w_refill_pop = w_run && r_req && w_can_pop;
    assign w_pop        = w_prime_pop || w_refill_pop;

    assign w_fv_rise    = frame_valid && !r_fv_d;
    assign w_fv_fall    = !frame_valid && r_fv_d;
    // A frame is armed from its rising edge onward, so the first pixel may
    // coincide with the rising edge itself.
    assign w_armed_now  = r_armed || (w_fv_rise && w_run);
    assign w_pix        = w_run && de && frame_valid && w_armed_now;
    assign w_bad_de     = de && frame_valid && !w_pix;
    assign w_switch     = w_pix && (r_rd_idx == c_LAST_IDX);
    assign w_run_cap    = w_run && r_rd_vld;
    assign w_uflow_evt  = w_switch && !w_run_cap && !r_next_ok;
    assign w_frame_end  = w_fv_fall && r_armed;
    assign w_cur_lane   = r_cur_word[int'(r_rd_idx)*PIX_W +: PIX_W];

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: prime two words (cur, next) between frames, then run
    always_comb begin
        w_state_nxt = r_state;
        w_prime_pop = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ready && !frame_valid) begin
                    w_state_nxt = ST_PRIME0;
                end
            end
            ST_PRIME0: begin
                if (w_can_pop) begin
                    w_prime_pop = 1'b1;
                    w_state_nxt = ST_PRIME1;
                end
            end
            ST_PRIME1: begin
                // First word lands here; the second pop cannot overlap the first.
                if (w_can_pop) begin
                    w_prime_pop = 1'b1;
                    w_state_nxt = ST_PRIME2;
                end
            end
            ST_PRIME2: begin
                if (r_rd_vld) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read FIFO pop strobe and the matching data-valid one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fifo_rd_en <= 1'b0;
            r_rd_vld     <= 1'b0;
        end else begin
            r_fifo_rd_en <= w_pop;
            r_rd_vld     <= r_fifo_rd_en;
        end
    end

    // Two-word read buffer: word switching, refill requests and underrun recovery
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_word  <= '0;
            r_next_word <= '0;
            r_next_ok   <= 1'b0;
            r_req       <= 1'b0;
            r_uflow     <= 1'b0;
        end else begin
            if (w_refill_pop) begin
                r_req <= 1'b0;
            end
            if ((r_state == ST_PRIME1) && r_rd_vld) begin
                r_cur_word <= fifo_rd_data;
            end
            if ((r_state == ST_PRIME2) && r_rd_vld) begin
                r_next_word <= fifo_rd_data;
                r_next_ok   <= 1'b1;
            end
            if (w_switch) begin
                r_next_ok <= 1'b0;
                if (w_run_cap) begin
                    // Refill arriving exactly at the switch goes straight to cur.
                    r_cur_word <= fifo_rd_data;
                    r_uflow    <= 1'b0;
                    r_req      <= 1'b1;
                end else if (r_next_ok) begin
                    r_cur_word <= r_next_word;
                    r_req      <= 1'b1;
                end else begin
                    // Underrun: emit zeros until the outstanding refill lands.
                    r_cur_word <= '0;
                    r_uflow    <= 1'b1;
                    if (!r_req && !r_uflow && !r_fifo_rd_en && !r_rd_vld) begin
                        r_req <= 1'b1;
                    end
                end
            end else if (w_run_cap) begin
                if (r_uflow) begin
                    r_cur_word <= fifo_rd_data;
                    r_uflow    <= 1'b0;
                    r_req      <= 1'b1;
                end else begin
                    r_next_word <= fifo_rd_data;
                    r_next_ok   <= 1'b1;
                end
            end
        end
    end

    // Per-pixel model output, one cycle after de
    always_ff @(posedge clk) begin
        if (rst) begin
            r_model_out   <= '0;
            r_model_valid <= 1'b0;
            r_rd_idx      <= '0;
        end else begin
            r_model_valid <= w_pix;
            if (w_pix) begin
                r_model_out <= w_cur_lane;
                r_rd_idx    <= (r_rd_idx == c_LAST_IDX) ? '0 : r_rd_idx + 1'b1;
            end
        end
    end

    // Frame envelope tracking and saturating pixel counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fv_d    <= 1'b0;
            r_armed   <= 1'b0;
            r_pix_cnt <= '0;
        end else begin
            r_fv_d <= frame_valid;
            if (w_fv_fall) begin
                r_armed <= 1'b0;
            end else if (w_fv_rise && w_run) begin
                r_armed <= 1'b1;
            end
            if (w_frame_end) begin
                r_pix_cnt <= '0;
            end else if (w_pix && (r_pix_cnt != c_CNT_MAX)) begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
            end
        end
    end

    // Sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_status <= '0;
        end else begin
            if (w_frame_end && ((r_pix_cnt != c_IMG_CNT) || (r_rd_idx != '0))) begin
                r_status[c_ST_FRAME] <= 1'b1;
            end
            if (w_frame_end && (r_wr_idx != '0)) begin
                r_status[c_ST_WRAL] <= 1'b1;
            end
            if (w_bad_de) begin
                r_status[c_ST_DE] <= 1'b1;
            end
            if (w_uflow_evt) begin
                r_status[c_ST_UFLOW] <= 1'b1;
            end
        end
    end

    // Write packer: current partial word with the incoming model merged in
    always_comb begin
        w_wr_merged = r_wr_word;
        w_wr_merged[int'(r_wr_idx)*PIX_W +: PIX_W] = model_in;
    end

    // Write packer: accumulate lanes and push each completed word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_idx       <= '0;
            r_wr_word      <= '0;
            r_fifo_wr_data <= '0;
            r_fifo_wr_en   <= 1'b0;
        end else begin
            r_fifo_wr_en <= 1'b0;
            if (model_in_valid) begin
                r_wr_word <= w_wr_merged;
                if (r_wr_idx == c_LAST_IDX) begin
                    r_wr_idx       <= '0;
                    r_fifo_wr_data <= w_wr_merged;
                    r_fifo_wr_en   <= 1'b1;
                end else begin
                    r_wr_idx <= r_wr_idx + 1'b1;
                end
            end
        end
    end

    assign fifo_rd_en   = r_fifo_rd_en;
    assign model_out    = r_model_out;
    assign model_valid  = r_model_valid;
    assign fifo_wr_data = r_fifo_wr_data;
    assign fifo_wr_en   = r_fifo_wr_en;
    assign status       = r_status;

endmodule
`default_nettype wire

// File: tb/tb_bg_word_bridge.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bg_word_bridge
//  Purpose  : Self-checking bench for bg_word_bridge (reduced frame size).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bg_word_bridge;

    localparam int c_PPW    = 16;
    localparam int c_TB_PIX = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ready = 1'b0;
    logic          frame_valid = 1'b0;
    logic          de = 1'b0;
    logic [1023:0] fifo_rd_data = '0;
    logic          fifo_rd_empty = 1'b1;
    logic          fifo_rd_en;
    logic [63:0]   model_out;
    logic          model_valid;
    logic [63:0]   model_in = '0;
    logic          model_in_valid = 1'b0;
    logic [1023:0] fifo_wr_data;
    logic          fifo_wr_en;
    logic [3:0]    status;

    int n_chk  = 0;
    int n_fail = 0;
    int fifo_k = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;

    bg_word_bridge #(
        .PIX_W        (64),
        .PIX_PER_WORD (c_PPW),
        .IMG_PIXELS   (c_TB_PIX)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ready          (ready),
        .frame_valid    (frame_valid),
        .de             (de),
        .fifo_rd_data   (fifo_rd_data),
        .fifo_rd_empty  (fifo_rd_empty),
        .fifo_rd_en     (fifo_rd_en),
        .model_out      (model_out),
        .model_valid    (model_valid),
        .model_in       (model_in),
        .model_in_valid (model_in_valid),
        .fifo_wr_data   (fifo_wr_data),
        .fifo_wr_en     (fifo_wr_en),
        .status         (status)
    );

    always #5 clk = ~clk;

    // Word k carries lane i = k*16 + i, so an unbroken stream yields model_out == pixel index.
    function automatic logic [1023:0] mk_word(input int k);
        logic [1023:0] w;
        w = '0;
        for (int i = 0; i < c_PPW; i++) w[i*64 +: 64] = 64'(k * c_PPW + i);
        return w;
    endfunction

    // Read FIFO model: data valid one cycle after the pop, flushed by reset
    always @(posedge clk) begin
        if (rst) begin
            fifo_k <= 0;
        end else if (fifo_rd_en) begin
            fifo_rd_data <= mk_word(fifo_k);
            fifo_k       <= fifo_k + 1;
        end
    end

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (fifo_rd_en) rd_pulses = rd_pulses + 1;
        if (fifo_wr_en) wr_pulses = wr_pulses + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One cycle of pixel/model traffic with an optional output check
    task automatic pixel(input logic d, input logic expv, input logic mv,
                         input logic [63:0] mval, input logic [63:0] expo, input string nm);
        de             = d;
        model_in_valid = mv;
        model_in       = mval;
        step();
        chk({nm, " valid"}, 64'(model_valid), 64'(expv));
        if (expv) chk({nm, " data"}, model_out, expo);
    endtask

    task automatic idle(input int n);
        de             = 1'b0;
        model_in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct {
        logic        de;
        logic        mv;
        logic [63:0] min;
        logic        exp_v;
        logic [63:0] exp_o;
        logic        exp_rd;
        logic        exp_wr;
        logic [63:0] wr_base;
    } vec_t;

    vec_t tbl[32];

    initial begin
        int g;
        int snap_rd;
        int snap_wr;

        for (int i = 0; i < 32; i++) begin
            tbl[i].de      = 1'b1;
            tbl[i].mv      = 1'b1;
            tbl[i].min     = (i < 16) ? 64'(32'h100 + i) : 64'(32'h200 + i - 16);
            tbl[i].exp_v   = 1'b1;
            tbl[i].exp_o   = 64'(i);
            tbl[i].exp_rd  = (i == 16);
            tbl[i].exp_wr  = (i == 15) || (i == 31);
            tbl[i].wr_base = (i == 15) ? 64'h100 : 64'h200;
        end

        // Reset state
        idle(3);
        chk("reset model_out", model_out, 64'd0);
        chk("reset model_valid", 64'(model_valid), 64'd0);
        chk("reset rd_en", 64'(fifo_rd_en), 64'd0);
        chk("reset wr_en", 64'(fifo_wr_en), 64'd0);
        chk("reset wr_data lane0", fifo_wr_data[63:0], 64'd0);
        chk("reset status", 64'(status), 64'd0);

        // Priming: exactly two pops, no other output activity
        rst = 1'b0;
        ready = 1'b1;
        fifo_rd_empty = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("prime quiet", 64'({model_valid, fifo_wr_en, status}), 64'd0);
        end
        chk("prime pops", 64'(rd_pulses), 64'd2);

        // Table-driven start of frame 1: 32 pixels, two write words
        frame_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            de             = tbl[i].de;
            model_in_valid = tbl[i].mv;
            model_in       = tbl[i].min;
            step();
            chk($sformatf("tbl[%0d] valid", i), 64'(model_valid), 64'(tbl[i].exp_v));
            chk($sformatf("tbl[%0d] data", i), model_out, tbl[i].exp_o);
            chk($sformatf("tbl[%0d] rd_en", i), 64'(fifo_rd_en), 64'(tbl[i].exp_rd));
            chk($sformatf("tbl[%0d] wr_en", i), 64'(fifo_wr_en), 64'(tbl[i].exp_wr));
            if (tbl[i].exp_wr) begin
                for (int j = 0; j < c_PPW; j++)
                    chk($sformatf("tbl[%0d] wr lane%0d", i, j), fifo_wr_data[j*64 +: 64],
                        tbl[i].wr_base + 64'(j));
            end
        end

        // Rest of the full frame
        g = 32;
        for (int p = 32; p < c_TB_PIX; p++) begin
            pixel(1'b1, 1'b1, 1'b1, 64'(p), 64'(g), "frame1");
            g++;
        end
        frame_valid = 1'b0;
        idle(4);
        chk("frame1 status", 64'(status), 64'd0);
        chk("frame1 pushes", 64'(wr_pulses), 64'(c_TB_PIX / c_PPW));
        chk("frame1 pops", 64'(rd_pulses), 64'(2 + c_TB_PIX / c_PPW));

        // Underrun: FIFO empty across a word switch
        fifo_rd_empty = 1'b1;
        snap_rd = rd_pulses;
        frame_valid = 1'b1;
        for (int q = 0; q < 36; q++) begin
            pixel(1'b1, 1'b1, 1'b0, 64'd0, (q >= 32) ? 64'd0 : 64'(g), "uflow");
            g++;
        end
        chk("uflow no pop while empty", 64'(rd_pulses), 64'(snap_rd));
        chk("uflow status", 64'(status), 64'h8);
        fifo_rd_empty = 1'b0;
        idle(10);
        chk("uflow recovery pops", 64'(rd_pulses), 64'(snap_rd + 2));
        for (int q = 36; q < c_TB_PIX; q++) begin
            pixel(1'b1, 1'b1, 1'b0, 64'd0, 64'(g), "resume");
            g++;
        end
        frame_valid = 1'b0;
        idle(4);
        chk("frame2 status", 64'(status), 64'h8);

        // Short frame with 8 extra model writes
        frame_valid = 1'b1;
        for (int q = 0; q < 1000; q++) begin
            pixel(1'b1, 1'b1, (q < 8), 64'(q), 64'(g), "short");
            g++;
        end
        frame_valid = 1'b0;
        idle(4);
        chk("short status", 64'(status), 64'hB);

        // Clean frame afterwards: flags stay sticky
        frame_valid = 1'b1;
        for (int q = 0; q < c_TB_PIX; q++) begin
            pixel(1'b1, 1'b1, 1'b1, 64'(q), 64'(g), "clean");
            g++;
        end
        frame_valid = 1'b0;
        idle(4);
        chk("clean status sticky", 64'(status), 64'hB);

        // Reset mid-frame drops partial words
        frame_valid = 1'b1;
        for (int q = 0; q < 20; q++) begin
            pixel(1'b1, 1'b1, 1'b1, 64'(q), 64'(g), "pre-reset");
            g++;
        end
        rst = 1'b1;
        idle(3);
        chk("midreset status", 64'(status), 64'd0);
        chk("midreset outputs", 64'({model_valid, fifo_wr_en, fifo_rd_en}), 64'd0);
        chk("midreset model_out", model_out, 64'd0);
        snap_wr = wr_pulses;
        snap_rd = rd_pulses;

        // Frame already running when priming completes is ignored
        rst = 1'b0;
        frame_valid = 1'b0;
        step();
        frame_valid = 1'b1;
        for (int q = 0; q < 20; q++)
            pixel(1'b1, 1'b0, (q < 8), 64'(q), 64'd0, "unarmed");
        chk("unarmed no push", 64'(wr_pulses), 64'(snap_wr));
        chk("unarmed pops", 64'(rd_pulses), 64'(snap_rd + 2));
        chk("unarmed status", 64'(status), 64'h4);
        frame_valid = 1'b0;
        idle(2);

        // Next frame is armed and starts from the reprimed words
        frame_valid = 1'b1;
        for (int q = 0; q < 20; q++)
            pixel(1'b1, 1'b1, 1'b0, 64'd0, 64'(q), "rearmed");
        chk("rearmed refill pop", 64'(rd_pulses), 64'(snap_rd + 3));
        frame_valid = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
